// File: rtl/dbus_pkg.sv
// Shared definitions for the DBus load/store unit: access-size and FSM state
// encodings plus the DBus word-address width.
package dbus_pkg;

  localparam int DBUS_ADDR_W = 30;

  // Access size as presented by the core pipeline.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } dbusSize_t;

  // LSU sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsuState_t;

endpackage

// File: rtl/dbus_lsu_if.sv
// Core-request and DBus signal bundle for the load/store unit.
// Core side: a request is accepted on a posedge where i_Req & o_Ready; the
// request fields are sampled only on that edge. o_Done pulses for exactly one
// cycle per accepted request, with o_Rd/o_Misaligned valid alongside it.
// Bus side: o_DBusRe/o_DBusWe are single-cycle strobes, address/enables/data
// are stable while a strobe is high; i_DBusRd is sampled READ_LATENCY cycles
// after the slave samples the read strobe.
interface dbus_lsu_if;
  import dbus_pkg::*;

  logic                   i_Req;
  logic                   i_We;
  logic [31:0]            i_Addr;
  logic [1:0]             i_Size;
  logic                   i_Unsigned;
  logic [31:0]            i_Wd;
  logic                   o_Ready;
  logic                   o_Done;
  logic [31:0]            o_Rd;
  logic                   o_Misaligned;
  logic [DBUS_ADDR_W-1:0] o_DBusAddr;
  logic                   o_DBusRe;
  logic                   o_DBusWe;
  logic [3:0]             o_DBusByteEn;
  logic [31:0]            o_DBusWd;
  logic [31:0]            i_DBusRd;

  // The LSU itself: slave to the core, master on the DBus.
  modport master (
    input  i_Req, i_We, i_Addr, i_Size, i_Unsigned, i_Wd, i_DBusRd,
    output o_Ready, o_Done, o_Rd, o_Misaligned,
    output o_DBusAddr, o_DBusRe, o_DBusWe, o_DBusByteEn, o_DBusWd
  );

  // The environment: core pipeline plus the selected RAM slave.
  modport slave (
    output i_Req, i_We, i_Addr, i_Size, i_Unsigned, i_Wd, i_DBusRd,
    input  o_Ready, o_Done, o_Rd, o_Misaligned,
    input  o_DBusAddr, o_DBusRe, o_DBusWe, o_DBusByteEn, o_DBusWd
  );

endinterface

// File: rtl/dbus_lane_align.sv
// Byte-lane steering: alignment check, byte enables and replicated store data
// on the way out; lane extraction and sign/zero extension on the way back.
module dbus_lane_align
  import dbus_pkg::*;
(
  input  logic [1:0]  i_Size,
  input  logic [1:0]  i_Offset,
  input  logic [31:0] i_Wd,
  input  logic        i_Unsigned,
  input  logic [31:0] i_RdWord,
  output logic [3:0]  o_ByteEn,
  output logic [31:0] o_WdRep,
  output logic        o_Misaligned,
  output logic [31:0] o_RdExt
);

  logic [31:0] rdShift;

  // Decode size/offset into lane enables, store data, fault flag and load result.
  always_comb begin
    rdShift      = i_RdWord >> {i_Offset, 3'b000};
    o_ByteEn     = 4'b0000;
    o_WdRep      = i_Wd;
    o_Misaligned = 1'b0;
    o_RdExt      = rdShift;
    case (i_Size)
      SIZE_BYTE: begin
        o_ByteEn = 4'b0001 << i_Offset;
        o_WdRep  = {4{i_Wd[7:0]}};
        o_RdExt  = {{24{~i_Unsigned & rdShift[7]}}, rdShift[7:0]};
      end
      SIZE_HALF: begin
        o_Misaligned = i_Offset[0];
        o_ByteEn     = 4'b0011 << i_Offset;
        o_WdRep      = {2{i_Wd[15:0]}};
        o_RdExt      = {{16{~i_Unsigned & rdShift[15]}}, rdShift[15:0]};
      end
      SIZE_WORD: begin
        o_Misaligned = |i_Offset;
        o_ByteEn     = 4'b1111;
      end
      default: o_Misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dbus_lsu.sv
// Load/store unit and DBus master: accepts one core request at a time, issues
// a single-cycle bus strobe, waits out the slave read latency and reports a
// one-cycle completion with the extended load result or an alignment fault.
module dbus_lsu
  import dbus_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  dbus_lsu_if.master bus,
  output lsuState_t  o_DbgState
);

  lsuState_t   state;
  logic [1:0]  latCnt;
  logic        weQ;
  logic [1:0]  sizeQ;
  logic [1:0]  offsetQ;
  logic        unsignedQ;

  logic [1:0]  alignSize;
  logic [1:0]  alignOffset;
  logic [3:0]  alignByteEn;
  logic [31:0] alignWdRep;
  logic        alignMisaligned;
  logic [31:0] alignRdExt;

  // Live request fields steer the aligner while idle (accept decision); the
  // latched copy steers it afterwards (load extraction).
  assign alignSize   = (state == ST_IDLE) ? bus.i_Size      : sizeQ;
  assign alignOffset = (state == ST_IDLE) ? bus.i_Addr[1:0] : offsetQ;

  dbus_lane_align u_align (
    .i_Size       (alignSize),
    .i_Offset     (alignOffset),
    .i_Wd         (bus.i_Wd),
    .i_Unsigned   (unsignedQ),
    .i_RdWord     (bus.i_DBusRd),
    .o_ByteEn     (alignByteEn),
    .o_WdRep      (alignWdRep),
    .o_Misaligned (alignMisaligned),
    .o_RdExt      (alignRdExt)
  );

  assign o_DbgState = state;

  // Request sequencing FSM with registered core and bus outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state            <= ST_IDLE;
      latCnt           <= '0;
      weQ              <= 1'b0;
      sizeQ            <= SIZE_BYTE;
      offsetQ          <= '0;
      unsignedQ        <= 1'b0;
      bus.o_Ready      <= 1'b1;
      bus.o_Done       <= 1'b0;
      bus.o_Rd         <= '0;
      bus.o_Misaligned <= 1'b0;
      bus.o_DBusAddr   <= '0;
      bus.o_DBusRe     <= 1'b0;
      bus.o_DBusWe     <= 1'b0;
      bus.o_DBusByteEn <= '0;
      bus.o_DBusWd     <= '0;
    end else begin
      bus.o_Done       <= 1'b0;
      bus.o_Misaligned <= 1'b0;
      bus.o_DBusRe     <= 1'b0;
      bus.o_DBusWe     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_Req) begin
            bus.o_Ready <= 1'b0;
            weQ         <= bus.i_We;
            sizeQ       <= bus.i_Size;
            offsetQ     <= bus.i_Addr[1:0];
            unsignedQ   <= bus.i_Unsigned;
            if (alignMisaligned) begin
              // Faulted requests complete immediately without touching the bus.
              bus.o_Done       <= 1'b1;
              bus.o_Misaligned <= 1'b1;
              state            <= ST_DONE;
            end else begin
              bus.o_DBusAddr   <= bus.i_Addr[31:2];
              bus.o_DBusByteEn <= alignByteEn;
              bus.o_DBusWd     <= alignWdRep;
              bus.o_DBusRe     <= ~bus.i_We;
              bus.o_DBusWe     <= bus.i_We;
              state            <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (weQ) begin
            bus.o_Done <= 1'b1;
            state      <= ST_DONE;
          end else begin
            latCnt <= 2'(READ_LATENCY - 1);
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (latCnt == 2'd0) begin
            bus.o_Rd   <= alignRdExt;
            bus.o_Done <= 1'b1;
            state      <= ST_DONE;
          end else begin
            latCnt <= latCnt - 2'd1;
          end
        end
        default: begin
          bus.o_Ready <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_lsu.sv
// Directed bench for dbus_lsu: one instance at read latency 1 on a small RAM
// slave, a second at read latency 2 sharing the same memory for back-to-back loads.
module tb_dbus_lsu;
  import dbus_pkg::*;

  logic      i_Clk;
  logic      i_Rst;
  lsuState_t dbg1;
  lsuState_t dbg2;
  int        nVec;
  int        nErr;

  dbus_lsu_if bus ();
  dbus_lsu_if bus2 ();

  dbus_lsu #(.READ_LATENCY(1)) u_dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .bus        (bus),
    .o_DbgState (dbg1)
  );

  dbus_lsu #(.READ_LATENCY(2)) u_dut2 (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .bus        (bus2),
    .o_DbgState (dbg2)
  );

  // ---------------- clock / reset ----------------
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // ---------------- RAM slave model ----------------
  logic [31:0] mem [16];
  logic [31:0] rdq1;
  logic [31:0] rdq2a;
  logic [31:0] rdq2b;

  always @(posedge i_Clk) begin
    if (bus.o_DBusWe)
      for (int i = 0; i < 4; i++)
        if (bus.o_DBusByteEn[i]) mem[bus.o_DBusAddr[3:0]][8*i +: 8] <= bus.o_DBusWd[8*i +: 8];
    if (bus.o_DBusRe) rdq1 <= mem[bus.o_DBusAddr[3:0]];
    if (bus2.o_DBusRe) rdq2a <= mem[bus2.o_DBusAddr[3:0]];
    rdq2b <= rdq2a;
  end

  assign bus.i_DBusRd  = rdq1;
  assign bus2.i_DBusRd = rdq2b;

  // ---------------- driver ----------------
  int          oDone;
  int          oStr;
  logic        oMis;
  logic [31:0] oRd;
  logic [3:0]  oBe;
  logic [31:0] oWd;
  logic [29:0] oAdr;
  logic        oRdy0;
  logic        oRdyB;
  logic        oMisA;

  // One request on the latency-1 instance; observations indexed from accept edge T.
  task automatic run_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
    oDone = -1; oStr = 0; oMis = 1'b0; oRd = '0; oBe = '0; oWd = '0; oAdr = '0;
    oRdyB = 1'b0; oMisA = 1'b1;
    @(negedge i_Clk);
    bus.i_We = we; bus.i_Addr = addr; bus.i_Size = size; bus.i_Unsigned = uns;
    bus.i_Wd = wd; bus.i_Req = 1'b1;
    @(posedge i_Clk); #1;
    // Scramble the inputs: the request must already be latched.
    bus.i_Req = 1'b0; bus.i_We = ~we; bus.i_Addr = 32'hFFFF_FFFF; bus.i_Size = 2'd3;
    bus.i_Unsigned = ~uns; bus.i_Wd = ~wd;
    oRdy0 = bus.o_Ready;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin @(posedge i_Clk); #1; end
      if (bus.o_DBusRe || bus.o_DBusWe) begin
        oStr = oStr + int'(bus.o_DBusRe) + int'(bus.o_DBusWe);
        oBe = bus.o_DBusByteEn; oWd = bus.o_DBusWd; oAdr = bus.o_DBusAddr;
      end
      if (oDone >= 0) begin
        oRdyB = bus.o_Ready; oMisA = bus.o_Misaligned;
        break;
      end
      if (bus.o_Done) begin
        oDone = k; oMis = bus.o_Misaligned; oRd = bus.o_Rd;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nVec++; if (bus.o_Ready !== 1'b1) begin nErr++; $display("FAIL rst_ready: got %b expected 1", bus.o_Ready); end
    nVec++; if (bus.o_Done !== 1'b0) begin nErr++; $display("FAIL rst_done: got %b expected 0", bus.o_Done); end
    nVec++; if (bus.o_Misaligned !== 1'b0) begin nErr++; $display("FAIL rst_mis: got %b expected 0", bus.o_Misaligned); end
    nVec++; if (bus.o_Rd !== 32'h0) begin nErr++; $display("FAIL rst_rd: got %h expected 0", bus.o_Rd); end
    nVec++; if ({bus.o_DBusRe, bus.o_DBusWe} !== 2'b00) begin nErr++; $display("FAIL rst_strobes: got %b expected 00", {bus.o_DBusRe, bus.o_DBusWe}); end
    nVec++; if (bus.o_DBusByteEn !== 4'h0) begin nErr++; $display("FAIL rst_be: got %b expected 0000", bus.o_DBusByteEn); end
    nVec++; if (bus.o_DBusAddr !== 30'h0) begin nErr++; $display("FAIL rst_addr: got %h expected 0", bus.o_DBusAddr); end
    nVec++; if (bus.o_DBusWd !== 32'h0) begin nErr++; $display("FAIL rst_wd: got %h expected 0", bus.o_DBusWd); end
    nVec++; if (dbg1 !== ST_IDLE) begin nErr++; $display("FAIL rst_state: got %0d expected %0d", dbg1, ST_IDLE); end
  endtask

  task automatic test_word();
    run_op(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF);
    nVec++; if (oDone !== 1) begin nErr++; $display("FAIL st_word_done_at: got %0d expected 1", oDone); end
    nVec++; if (oStr !== 1) begin nErr++; $display("FAIL st_word_strobes: got %0d expected 1", oStr); end
    nVec++; if (oBe !== 4'b1111) begin nErr++; $display("FAIL st_word_be: got %b expected 1111", oBe); end
    nVec++; if (oAdr !== 30'd4) begin nErr++; $display("FAIL st_word_addr: got %h expected 4", oAdr); end
    nVec++; if (oWd !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL st_word_wd: got %h expected deadbeef", oWd); end
    nVec++; if (oRdy0 !== 1'b0) begin nErr++; $display("FAIL st_word_ready_drop: got %b expected 0", oRdy0); end
    nVec++; if (oRdyB !== 1'b1) begin nErr++; $display("FAIL st_word_ready_back: got %b expected 1", oRdyB); end
    nVec++; if (oMis !== 1'b0) begin nErr++; $display("FAIL st_word_mis: got %b expected 0", oMis); end
    run_op(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    nVec++; if (oDone !== 2) begin nErr++; $display("FAIL ld_word_done_at: got %0d expected 2", oDone); end
    nVec++; if (oRd !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL ld_word_rd: got %h expected deadbeef", oRd); end
    nVec++; if (oBe !== 4'b1111) begin nErr++; $display("FAIL ld_word_be: got %b expected 1111", oBe); end
    nVec++; if (oStr !== 1) begin nErr++; $display("FAIL ld_word_strobes: got %0d expected 1", oStr); end
  endtask

  task automatic test_byte();
    run_op(1'b1, 32'h13, 2'd0, 1'b0, 32'h1234_56A5);
    nVec++; if (oBe !== 4'b1000) begin nErr++; $display("FAIL st_byte_be: got %b expected 1000", oBe); end
    nVec++; if (oWd !== 32'hA5A5_A5A5) begin nErr++; $display("FAIL st_byte_wd: got %h expected a5a5a5a5", oWd); end
    nVec++; if (oAdr !== 30'd4) begin nErr++; $display("FAIL st_byte_addr: got %h expected 4", oAdr); end
    run_op(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
    nVec++; if (oRd !== 32'hFFFF_FFA5) begin nErr++; $display("FAIL ld_byte_s: got %h expected ffffffa5", oRd); end
    run_op(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
    nVec++; if (oRd !== 32'h0000_00A5) begin nErr++; $display("FAIL ld_byte_u: got %h expected 000000a5", oRd); end
    run_op(1'b0, 32'h11, 2'd0, 1'b1, 32'h0);
    nVec++; if (oRd !== 32'h0000_00BE) begin nErr++; $display("FAIL ld_byte1_u: got %h expected 000000be", oRd); end
    nVec++; if (oBe !== 4'b0010) begin nErr++; $display("FAIL ld_byte1_be: got %b expected 0010", oBe); end
  endtask

  task automatic test_half();
    run_op(1'b1, 32'h4, 2'd2, 1'b0, 32'h8001_7FFF);
    nVec++; if (oRd !== 32'h0000_00BE) begin nErr++; $display("FAIL st_keeps_rd: got %h expected 000000be", oRd); end
    run_op(1'b0, 32'h6, 2'd1, 1'b0, 32'h0);
    nVec++; if (oRd !== 32'hFFFF_8001) begin nErr++; $display("FAIL ld_half6_s: got %h expected ffff8001", oRd); end
    nVec++; if (oBe !== 4'b1100) begin nErr++; $display("FAIL ld_half6_be: got %b expected 1100", oBe); end
    run_op(1'b0, 32'h4, 2'd1, 1'b0, 32'h0);
    nVec++; if (oRd !== 32'h0000_7FFF) begin nErr++; $display("FAIL ld_half4_s: got %h expected 00007fff", oRd); end
    run_op(1'b0, 32'h6, 2'd1, 1'b1, 32'h0);
    nVec++; if (oRd !== 32'h0000_8001) begin nErr++; $display("FAIL ld_half6_u: got %h expected 00008001", oRd); end
    run_op(1'b1, 32'h6, 2'd1, 1'b0, 32'hABCD_1234);
    nVec++; if (oBe !== 4'b1100) begin nErr++; $display("FAIL st_half_be: got %b expected 1100", oBe); end
    nVec++; if (oWd !== 32'h1234_1234) begin nErr++; $display("FAIL st_half_wd: got %h expected 12341234", oWd); end
    run_op(1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
    nVec++; if (oRd !== 32'h1234_7FFF) begin nErr++; $display("FAIL ld_after_half_st: got %h expected 12347fff", oRd); end
  endtask

  task automatic test_fault();
    logic        weV   [3];
    logic [31:0] addrV [3];
    logic [1:0]  sizeV [3];
    weV[0] = 1'b0; addrV[0] = 32'h2; sizeV[0] = 2'd2;
    weV[1] = 1'b0; addrV[1] = 32'h1; sizeV[1] = 2'd1;
    weV[2] = 1'b1; addrV[2] = 32'h0; sizeV[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      run_op(weV[i], addrV[i], sizeV[i], 1'b0, 32'h5555_AAAA);
      nVec++; if (oStr !== 0) begin nErr++; $display("FAIL fault%0d_strobes: got %0d expected 0", i, oStr); end
      nVec++; if (oDone !== 0) begin nErr++; $display("FAIL fault%0d_done_at: got %0d expected 0", i, oDone); end
      nVec++; if (oMis !== 1'b1) begin nErr++; $display("FAIL fault%0d_mis: got %b expected 1", i, oMis); end
      nVec++; if (oMisA !== 1'b0) begin nErr++; $display("FAIL fault%0d_mis_clear: got %b expected 0", i, oMisA); end
      nVec++; if (oRdyB !== 1'b1) begin nErr++; $display("FAIL fault%0d_ready_back: got %b expected 1", i, oRdyB); end
      nVec++; if (oRd !== 32'h1234_7FFF) begin nErr++; $display("FAIL fault%0d_rd_kept: got %h expected 12347fff", i, oRd); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrV [3];
    logic [1:0]  sizeV [3];
    logic        unsV  [3];
    logic [31:0] expV  [3];
    int          acc   [3];
    int          dn    [3];
    int          reCnt [3];
    logic [31:0] rdV   [3];
    int          idx;
    int          dIdx;
    int          rdyBad;
    int          overlap;
    logic        willAccept;
    addrV[0] = 32'h10; sizeV[0] = 2'd2; unsV[0] = 1'b0; expV[0] = 32'hA5AD_BEEF;
    addrV[1] = 32'h06; sizeV[1] = 2'd1; unsV[1] = 1'b1; expV[1] = 32'h0000_1234;
    addrV[2] = 32'h13; sizeV[2] = 2'd0; unsV[2] = 1'b0; expV[2] = 32'hFFFF_FFA5;
    for (int i = 0; i < 3; i++) begin acc[i] = -100; dn[i] = -1; reCnt[i] = 0; rdV[i] = '0; end
    idx = 0; dIdx = 0; rdyBad = 0; overlap = 0;
    @(negedge i_Clk);
    bus2.i_We = 1'b0; bus2.i_Addr = addrV[0]; bus2.i_Size = sizeV[0];
    bus2.i_Unsigned = unsV[0]; bus2.i_Req = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      willAccept = bus2.o_Ready && bus2.i_Req;
      @(posedge i_Clk); #1;
      if (willAccept) begin
        acc[idx] = cyc; idx++;
        if (idx < 3) begin
          bus2.i_Addr = addrV[idx]; bus2.i_Size = sizeV[idx]; bus2.i_Unsigned = unsV[idx];
        end else bus2.i_Req = 1'b0;
      end
      if (bus2.o_DBusRe && idx > 0) reCnt[idx-1]++;
      if (bus2.o_Done && bus2.o_DBusRe) overlap++;
      if (idx > dIdx && dIdx < 3 && bus2.o_Ready) rdyBad++;
      if (bus2.o_Done && dIdx < 3) begin dn[dIdx] = cyc; rdV[dIdx] = bus2.o_Rd; dIdx++; end
      if (dIdx == 3) break;
      @(negedge i_Clk);
    end
    for (int i = 0; i < 3; i++) begin
      nVec++; if (dn[i] - acc[i] !== 3) begin nErr++; $display("FAIL b2b%0d_latency: got %0d expected 3", i, dn[i] - acc[i]); end
      nVec++; if (reCnt[i] !== 1) begin nErr++; $display("FAIL b2b%0d_strobes: got %0d expected 1", i, reCnt[i]); end
      nVec++; if (rdV[i] !== expV[i]) begin nErr++; $display("FAIL b2b%0d_rd: got %h expected %h", i, rdV[i], expV[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      nVec++; if (acc[i] - dn[i-1] !== 2) begin nErr++; $display("FAIL b2b%0d_reissue_gap: got %0d expected 2", i, acc[i] - dn[i-1]); end
    end
    nVec++; if (rdyBad !== 0) begin nErr++; $display("FAIL b2b_ready_busy: got %0d expected 0", rdyBad); end
    nVec++; if (overlap !== 0) begin nErr++; $display("FAIL b2b_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_reset_mid();
    int doneSeen;
    doneSeen = 0;
    @(negedge i_Clk);
    bus.i_We = 1'b0; bus.i_Addr = 32'h10; bus.i_Size = 2'd2; bus.i_Unsigned = 1'b0; bus.i_Req = 1'b1;
    @(posedge i_Clk); #1;
    bus.i_Req = 1'b0;
    nVec++; if (bus.o_DBusRe !== 1'b1) begin nErr++; $display("FAIL rmid_issue_re: got %b expected 1", bus.o_DBusRe); end
    @(posedge i_Clk); #1;
    nVec++; if (dbg1 !== ST_WAIT) begin nErr++; $display("FAIL rmid_in_wait: got %0d expected %0d", dbg1, ST_WAIT); end
    i_Rst = 1'b1; #1;
    nVec++; if (bus.o_DBusRe !== 1'b0) begin nErr++; $display("FAIL rmid_re: got %b expected 0", bus.o_DBusRe); end
    nVec++; if (bus.o_DBusByteEn !== 4'h0) begin nErr++; $display("FAIL rmid_be: got %b expected 0000", bus.o_DBusByteEn); end
    nVec++; if (dbg1 !== ST_IDLE) begin nErr++; $display("FAIL rmid_state: got %0d expected %0d", dbg1, ST_IDLE); end
    repeat (3) begin
      @(posedge i_Clk); #1;
      if (bus.o_Done || bus.o_DBusRe) doneSeen++;
    end
    @(negedge i_Clk); i_Rst = 1'b0;
    @(posedge i_Clk); #1;
    if (bus.o_Done || bus.o_DBusRe) doneSeen++;
    nVec++; if (doneSeen !== 0) begin nErr++; $display("FAIL rmid_no_completion: got %0d expected 0", doneSeen); end
    nVec++; if (bus.o_Ready !== 1'b1) begin nErr++; $display("FAIL rmid_ready: got %b expected 1", bus.o_Ready); end
    run_op(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    nVec++; if (oDone !== 2) begin nErr++; $display("FAIL rmid_next_done_at: got %0d expected 2", oDone); end
    nVec++; if (oRd !== 32'hA5AD_BEEF) begin nErr++; $display("FAIL rmid_next_rd: got %h expected a5adbeef", oRd); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    nVec = 0; nErr = 0;
    i_Rst = 1'b1;
    bus.i_Req = 1'b0; bus.i_We = 1'b0; bus.i_Addr = '0; bus.i_Size = '0; bus.i_Unsigned = 1'b0; bus.i_Wd = '0;
    bus2.i_Req = 1'b0; bus2.i_We = 1'b0; bus2.i_Addr = '0; bus2.i_Size = '0; bus2.i_Unsigned = 1'b0; bus2.i_Wd = '0;
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk); i_Rst = 1'b0;
    @(negedge i_Clk);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
